dec_seq: RTL and testbench

//  Registered, parametrised N-to-2^N one-hot decoder; next generation of the fixed 3-to-8 decoder.

---
 rtl/dec_seq.sv | 162 ++++++++++++++++
 tb/tb_dec_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dec_seq.sv
// dec_seq: registered N-to-2**N one-hot decoder with handshake and hold time.
// Define DEC_SWEEP_EN to build the SWEEP scanning mode (off by default).
module dec_seq #(
    parameter int N        = 3,
    parameter int HOLD_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [N-1:0]     addr,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [2**N-1:0]  D,
    output logic             out_valid,
    output logic             sweep_done
);

    localparam int W = 2**N;
    localparam logic [W-1:0] ONE = W'(1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);

`ifdef DEC_SWEEP_EN
    localparam logic SWEEP_ON = 1'b1;
`else
    localparam logic SWEEP_ON = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1
`ifdef DEC_SWEEP_EN
        ,
        SWEEP = 2'd2
`endif
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       hold_end;

    assign hold_end = (cnt == HOLD_LAST);

    // Accept a new address only when idle and not about to start a sweep.
    assign in_ready = en & (state == IDLE) & ~(mode & SWEEP_ON);

`ifdef DEC_SWEEP_EN
    logic [N-1:0] idx;
    logic [N-1:0] idx_nxt;
    logic         last_code;

    assign idx_nxt   = idx + 1'b1;
    assign last_code = (idx == N'(W - 1));

    // Pulse only during the final enabled cycle of the last code.
    assign sweep_done = en & (state == SWEEP) & last_code & hold_end;

    // Main sequencer: decode, hold timing and sweep walk, all frozen by en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            D         <= '0;
            out_valid <= 1'b0;
            cnt       <= '0;
            idx       <= '0;
        end else if (en) begin
            unique case (state)
                IDLE: begin
                    if (mode) begin
                        state     <= SWEEP;
                        D         <= ONE;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        idx       <= '0;
                    end else if (in_valid) begin
                        state     <= HOLD;
                        D         <= ONE << addr;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                    end
                end
                HOLD: begin
                    if (hold_end) begin
                        state     <= IDLE;
                        D         <= '0;
                        out_valid <= 1'b0;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                SWEEP: begin
                    if (!hold_end) begin
                        cnt <= cnt + 8'd1;
                    end else begin
                        cnt <= '0;
                        if (!last_code) begin
                            idx <= idx_nxt;
                            D   <= ONE << idx_nxt;
                        end else if (mode) begin
                            idx <= '0;
                            D   <= ONE;
                        end else begin
                            state     <= IDLE;
                            idx       <= '0;
                            D         <= '0;
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    D         <= '0;
                    out_valid <= 1'b0;
                    cnt       <= '0;
                    idx       <= '0;
                end
            endcase
        end
    end
`else
    assign sweep_done = 1'b0;

    // Main sequencer: direct decode with hold timing, frozen by en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            D         <= '0;
            out_valid <= 1'b0;
            cnt       <= '0;
        end else if (en) begin
            unique case (state)
                IDLE: begin
                    if (in_valid & in_ready) begin
                        state     <= HOLD;
                        D         <= ONE << addr;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                    end
                end
                HOLD: begin
                    if (hold_end) begin
                        state     <= IDLE;
                        D         <= '0;
                        out_valid <= 1'b0;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    D         <= '0;
                    out_valid <= 1'b0;
                    cnt       <= '0;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_dec_seq.sv
// tb_dec_seq: directed, table-driven bench for dec_seq (N=3, HOLD_CYC=2).
// Sweep checks run when DEC_SWEEP_EN is defined, direct-only checks otherwise.
module tb_dec_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       mode;
    logic [2:0] addr;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] D;
    logic       out_valid;
    logic       sweep_done;

    int n_chk  = 0;
    int n_fail = 0;
    bit mon_on = 1'b0;

    dec_seq #(.N(3), .HOLD_CYC(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .addr       (addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .D          (D),
        .out_valid  (out_valid),
        .sweep_done (sweep_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] a;
        logic [7:0] exp_d;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // D must never be multi-hot.
    always @(negedge clk) begin
        if (mon_on) begin
            n_chk++;
            if ((D & (D - 8'd1)) != 8'd0) begin
                n_fail++;
                $display("FAIL onehot: got %0h expected zero or one-hot", D);
            end
        end
    end

    initial begin
        vecs[0] = '{3'd0, 8'h01};
        vecs[1] = '{3'd1, 8'h02};
        vecs[2] = '{3'd2, 8'h04};
        vecs[3] = '{3'd3, 8'h08};
        vecs[4] = '{3'd4, 8'h10};
        vecs[5] = '{3'd5, 8'h20};
        vecs[6] = '{3'd6, 8'h40};
        vecs[7] = '{3'd7, 8'h80};

        rst = 1'b1;
        en = 1'b0;
        mode = 1'b0;
        addr = '0;
        in_valid = 1'b0;
        step();
        step();
        check("rst_d", D, 8'h00);
        check("rst_ov", out_valid, 1'b0);
        check("rst_sd", sweep_done, 1'b0);
        rst = 1'b0;
        en = 1'b1;
        mon_on = 1'b1;
        #1;
        check("rst_rdy", in_ready, 1'b1);

        // Direct decode of addr 5
        addr = 3'd5;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("d5_t1", D, 8'h20);
        check("d5_ov1", out_valid, 1'b1);
        check("d5_rdy1", in_ready, 1'b0);
        step();
        check("d5_t2", D, 8'h20);
        check("d5_rdy2", in_ready, 1'b0);
        step();
        check("d5_t3", D, 8'h00);
        check("d5_ov3", out_valid, 1'b0);
        check("d5_rdy3", in_ready, 1'b1);

        // Exhaustive table, in_valid held high back to back
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            int budget;
            addr = vecs[i].a;
            budget = 0;
            while (!in_ready && budget < 20) begin
                step();
                budget++;
            end
            check("tbl_rdy", in_ready, 1'b1);
            step();
            check("tbl_d1", D, vecs[i].exp_d);
            check("tbl_ov", out_valid, 1'b1);
            step();
            check("tbl_d2", D, vecs[i].exp_d);
            check("tbl_rdy_hold", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        step();
        check("tbl_end", D, 8'h00);

        // Freeze during hold of addr 2
        addr = 3'd2;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("frz_d0", D, 8'h04);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("frz_d", D, 8'h04);
            check("frz_ov", out_valid, 1'b1);
            check("frz_rdy", in_ready, 1'b0);
        end
        en = 1'b1;
        step();
        check("frz_d_res", D, 8'h04);
        step();
        check("frz_d_end", D, 8'h00);
        check("frz_rdy_end", in_ready, 1'b1);

        // Asynchronous reset in the middle of a hold
        addr = 3'd6;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("arst_pre", D, 8'h40);
        #3 rst = 1'b1;
        #1;
        check("arst_d", D, 8'h00);
        check("arst_ov", out_valid, 1'b0);
        step();
        rst = 1'b0;

`ifdef DEC_SWEEP_EN
        // Sweep entry has priority over a pending address
        mode = 1'b1;
        addr = 3'd7;
        in_valid = 1'b1;
        #1;
        check("sw_rdy", in_ready, 1'b0);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] e;
            e = 8'h01 << (i / 2);
            check("sw_d", D, e);
            check("sw_ov", out_valid, 1'b1);
            check("sw_done", sweep_done, (i == 15) ? 1'b1 : 1'b0);
            step();
        end
        check("sw_wrap", D, 8'h01);
        check("sw_wrap_sd", sweep_done, 1'b0);
        mode = 1'b0;
        step();
        for (int i = 1; i < 16; i++) begin
            logic [7:0] e;
            e = 8'h01 << (i / 2);
            check("sw2_d", D, e);
            check("sw2_done", sweep_done, (i == 15) ? 1'b1 : 1'b0);
            step();
        end
        check("sw_stop_d", D, 8'h00);
        check("sw_stop_ov", out_valid, 1'b0);
        check("sw_stop_rdy", in_ready, 1'b1);

        // Reset pulse mid-sweep
        mode = 1'b1;
        step();
        step();
        step();
        check("sw_mid", D, 8'h02);
        #3 rst = 1'b1;
        #1;
        check("sw_arst", D, 8'h00);
        check("sw_arst_sd", sweep_done, 1'b0);
        mode = 1'b0;
        step();
        rst = 1'b0;
`else
        // mode is ignored without sweep support
        mode = 1'b1;
        addr = 3'd7;
        in_valid = 1'b0;
        step();
        check("ns_idle", D, 8'h00);
        check("ns_rdy", in_ready, 1'b1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("ns_d1", D, 8'h80);
        check("ns_sd1", sweep_done, 1'b0);
        step();
        check("ns_d2", D, 8'h80);
        check("ns_sd2", sweep_done, 1'b0);
        step();
        check("ns_d3", D, 8'h00);
        check("ns_sd3", sweep_done, 1'b0);
        mode = 1'b0;
`endif

        step();
        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
